itch_dispatch_controller: RTL and testbench

- Sequences the ITCH message-type decoder and the per-type field parsers across one packet of back-to-back messages on the 64-bit word stream.
- Owns the "whose turn is it" decision: which parser has finished, where the next message starts in the word (tracker), how many messages remain, and when to skip unknown types.
- Replaces the ad-hoc combinational signal_end OR / tracker mux between decoder and parsers with a registered, watchdog-protected FSM.

---
 rtl/itch_pkg.sv | 31 +++
 rtl/itch_end_arbiter.sv | 36 +++
 rtl/itch_dispatch_controller.sv | 209 ++++++++++++++++++++
 tb/tb_itch_dispatch_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// Shared definitions for the ITCH message dispatch path.
// Holds the dispatch FSM state encoding, the word/tracker geometry and the
// message-type byte values recognised by the type decoder.
package itch_pkg;

  localparam int WORD_W = 64;
  // Tracker is a bit offset inside one 64-bit word, always byte aligned.
  localparam int TRK_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TYPE,
    PARSE,
    SKIP,
    DONE,
    ERROR
  } state_t;

  // Message type bytes (ASCII) handled by the decoder / parser bank.
  localparam logic [7:0] MSG_SYSTEM_EVENT    = 8'h53; // 'S'
  localparam logic [7:0] MSG_STOCK_DIRECTORY = 8'h52; // 'R'
  localparam logic [7:0] MSG_ADD_ORDER       = 8'h41; // 'A'
  localparam logic [7:0] MSG_ADD_ORDER_MPID  = 8'h46; // 'F'
  localparam logic [7:0] MSG_ORDER_EXECUTED  = 8'h45; // 'E'
  localparam logic [7:0] MSG_ORDER_EXEC_PX   = 8'h43; // 'C'
  localparam logic [7:0] MSG_ORDER_CANCEL    = 8'h58; // 'X'
  localparam logic [7:0] MSG_ORDER_DELETE    = 8'h44; // 'D'
  localparam logic [7:0] MSG_ORDER_REPLACE   = 8'h55; // 'U'
  localparam logic [7:0] MSG_TRADE           = 8'h50; // 'P'

endpackage

// File: rtl/itch_end_arbiter.sv
// Fixed-priority selection among parser end pulses.
// Ports:
//   end_vec  - per-parser signal_end pulses (index 0 = highest priority)
//   trk_vec  - packed trackerOut values, parser i at [i*TRK_W +: TRK_W]
//   sel_idx  - index of the lowest set end bit (0 when none set)
//   sel_trk  - tracker of the selected parser (0 when none set)
//   multi    - two or more end bits set in the same cycle
module itch_end_arbiter #(
  parameter int NUM_PARSERS = 8,
  parameter int TRK_W       = itch_pkg::TRK_W,
  parameter int IDX_W       = (NUM_PARSERS > 1) ? $clog2(NUM_PARSERS) : 1
) (
  input  logic [NUM_PARSERS-1:0]       end_vec,
  input  logic [NUM_PARSERS*TRK_W-1:0] trk_vec,
  output logic [IDX_W-1:0]             sel_idx,
  output logic [TRK_W-1:0]             sel_trk,
  output logic                         multi
);
  import itch_pkg::*;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    sel_idx = '0;
    sel_trk = '0;
    for (int i = NUM_PARSERS - 1; i >= 0; i--) begin
      if (end_vec[i]) begin
        sel_idx = IDX_W'(i);
        sel_trk = trk_vec[i*TRK_W +: TRK_W];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if more than one was set.
  assign multi = |(end_vec & (end_vec - NUM_PARSERS'(1)));

endmodule

// File: rtl/itch_dispatch_controller.sv
// Registered dispatch FSM between the ITCH type decoder and the parser bank.
// Decides whose turn it is within a packet of back-to-back messages: starts
// the decoder at the right tracker, waits for the owning parser (or skips an
// unknown message by length), counts messages down and guards every wait on
// the decoder/parsers with a watchdog.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   dataValid         - current word valid; advances the skip counter
//   packetStart       - new packet present (taken in IDLE/ERROR only)
//   messageCount      - messages in the packet, taken with packetStart
//   typeValid         - decoder resolved type/length this cycle
//   typeKnown         - a parser exists for the decoded type
//   messageLength     - byte length of the current message
//   parserEnd         - per-parser end pulses
//   parserTracker     - packed per-parser next-message trackers
//   startDecode       - one-cycle decoder start pulse
//   trackerToDecoder  - start bit offset handed to the decoder
//   busy              - high in every state except IDLE
//   packetDone        - one-cycle pulse when the packet is consumed
//   messagesLeft      - remaining message count
//   errTimeout        - sticky watchdog expiry
//   errMultiEnd       - sticky simultaneous parser ends
module itch_dispatch_controller #(
  parameter int NUM_PARSERS    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TRK_W          = itch_pkg::TRK_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dataValid,
  input  logic                         packetStart,
  input  logic [15:0]                  messageCount,
  input  logic                         typeValid,
  input  logic                         typeKnown,
  input  logic [15:0]                  messageLength,
  input  logic [NUM_PARSERS-1:0]       parserEnd,
  input  logic [NUM_PARSERS*TRK_W-1:0] parserTracker,
  output logic                         startDecode,
  output logic [TRK_W-1:0]             trackerToDecoder,
  output logic                         busy,
  output logic                         packetDone,
  output logic [15:0]                  messagesLeft,
  output logic                         errTimeout,
  output logic                         errMultiEnd
);
  import itch_pkg::*;

  localparam int IDX_W = (NUM_PARSERS > 1) ? $clog2(NUM_PARSERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [15:0]       msgs_q, msgs_d;
  logic [TRK_W-1:0]  trk_q, trk_d;
  logic              start_q, start_d;
  logic [13:0]       skip_q, skip_d;
  logic [TRK_W-1:0]  next_trk_q, next_trk_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_to_q, err_to_d;
  logic              err_me_q, err_me_d;

  logic [IDX_W-1:0]  sel_idx;
  logic [TRK_W-1:0]  sel_trk;
  logic              multi;
  logic              end_hit;
  logic [16:0]       tot;
  logic              fin;
  logic [TRK_W-1:0]  fin_trk;

  itch_end_arbiter #(
    .NUM_PARSERS (NUM_PARSERS),
    .TRK_W       (TRK_W),
    .IDX_W       (IDX_W)
  ) u_arb (
    .end_vec (parserEnd),
    .trk_vec (parserTracker),
    .sel_idx (sel_idx),
    .sel_trk (sel_trk),
    .multi   (multi)
  );

  // The selected index points at a set bit whenever any bit is set, and at
  // bit 0 (clear) otherwise, so this doubles as the "some parser ended" flag.
  assign end_hit = parserEnd[sel_idx];

  // Byte position just past the unknown message, counted from the start of
  // the current word: whole words to skip in [16:3], byte-in-word in [2:0].
  assign tot = 17'(trk_q >> 3) + 17'(messageLength);

  always_comb begin
    state_d    = state_q;
    msgs_d     = msgs_q;
    trk_d      = trk_q;
    start_d    = 1'b0;
    skip_d     = skip_q;
    next_trk_d = next_trk_q;
    wd_d       = '0;
    err_to_d   = err_to_q;
    err_me_d   = err_me_q;
    fin        = 1'b0;
    fin_trk    = '0;

    unique case (state_q)
      IDLE, ERROR: begin
        if (packetStart && dataValid) begin
          msgs_d   = messageCount;
          err_to_d = 1'b0;
          err_me_d = 1'b0;
          if (messageCount == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_TYPE;
            start_d = 1'b1;
            trk_d   = '0;
          end
        end
      end

      WAIT_TYPE: begin
        if (typeValid) begin
          if (typeKnown) begin
            state_d = PARSE;
          end else begin
            skip_d     = tot[16:3];
            next_trk_d = TRK_W'({tot[2:0], 3'b000});
            state_d    = SKIP;
          end
        end else if (wd_q == WD_LAST) begin
          err_to_d = 1'b1;
          state_d  = ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      PARSE: begin
        if (end_hit) begin
          fin     = 1'b1;
          fin_trk = sel_trk;
          if (multi) err_me_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          err_to_d = 1'b1;
          state_d  = ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      // Stalls on dataValid legitimately, so no watchdog here.
      SKIP: begin
        if (skip_q == 14'd0) begin
          fin     = 1'b1;
          fin_trk = next_trk_q;
        end else if (dataValid) begin
          skip_d = skip_q - 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Common end-of-message handling for parser ends and completed skips.
    if (fin) begin
      msgs_d = (msgs_q == 16'd0) ? 16'd0 : msgs_q - 1'b1;
      if (msgs_q <= 16'd1) begin
        state_d = DONE;
      end else begin
        state_d = WAIT_TYPE;
        start_d = 1'b1;
        trk_d   = fin_trk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      msgs_q     <= '0;
      trk_q      <= '0;
      start_q    <= 1'b0;
      skip_q     <= '0;
      next_trk_q <= '0;
      wd_q       <= '0;
      err_to_q   <= 1'b0;
      err_me_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      msgs_q     <= msgs_d;
      trk_q      <= trk_d;
      start_q    <= start_d;
      skip_q     <= skip_d;
      next_trk_q <= next_trk_d;
      wd_q       <= wd_d;
      err_to_q   <= err_to_d;
      err_me_q   <= err_me_d;
    end
  end

  assign startDecode      = start_q;
  assign trackerToDecoder = trk_q;
  assign busy             = (state_q != IDLE);
  assign packetDone       = (state_q == DONE);
  assign messagesLeft     = msgs_q;
  assign errTimeout       = err_to_q;
  assign errMultiEnd      = err_me_q;

endmodule

// File: tb/tb_itch_dispatch_controller.sv
// Scoreboard bench for itch_dispatch_controller: directed packets push the
// expected startDecode / packetDone events into a queue at the moment the
// causing stimulus is driven; a negedge monitor pops and compares each event.
module tb_itch_dispatch_controller;
  import itch_pkg::*;

  localparam int NP = 8;
  localparam int TW = 6;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          dataValid;
  logic          packetStart;
  logic [15:0]   messageCount;
  logic          typeValid;
  logic          typeKnown;
  logic [15:0]   messageLength;
  logic [NP-1:0] parserEnd;
  logic [NP*TW-1:0] parserTracker;
  logic          startDecode;
  logic [TW-1:0] trackerToDecoder;
  logic          busy;
  logic          packetDone;
  logic [15:0]   messagesLeft;
  logic          errTimeout;
  logic          errMultiEnd;

  itch_dispatch_controller #(
    .NUM_PARSERS    (NP),
    .TIMEOUT_CYCLES (TO),
    .TRK_W          (TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dataValid        (dataValid),
    .packetStart      (packetStart),
    .messageCount     (messageCount),
    .typeValid        (typeValid),
    .typeKnown        (typeKnown),
    .messageLength    (messageLength),
    .parserEnd        (parserEnd),
    .parserTracker    (parserTracker),
    .startDecode      (startDecode),
    .trackerToDecoder (trackerToDecoder),
    .busy             (busy),
    .packetDone       (packetDone),
    .messagesLeft     (messagesLeft),
    .errTimeout       (errTimeout),
    .errMultiEnd      (errMultiEnd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_done;
    logic [TW-1:0] trk;
    logic [15:0]   left;
    logic          me;
    logic          to;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*TW-1:0] trk_at(input int idx, input logic [TW-1:0] val);
    logic [NP*TW-1:0] w;
    w = '0;
    w[idx*TW +: TW] = val;
    return w;
  endfunction

  function automatic ev_t ev_start(input logic [TW-1:0] trk, input logic [15:0] left,
                                   input logic me, input logic to);
    ev_t e;
    e = '{is_done: 1'b0, trk: trk, left: left, me: me, to: to};
    return e;
  endfunction

  function automatic ev_t ev_done(input logic me, input logic to);
    ev_t e;
    e = '{is_done: 1'b1, trk: '0, left: 16'd0, me: me, to: to};
    return e;
  endfunction

  // Monitor: every output event must match the oldest pending expectation.
  initial begin
    ev_t act;
    ev_t req;
    forever begin
      @(negedge clk);
      if (!rst && (startDecode || packetDone)) begin
        if (startDecode && packetDone) begin
          total++;
          bad++;
          $display("FAIL start_and_done_same_cycle actual=11 required=one_of");
        end
        act = '{is_done: packetDone, trk: (packetDone ? '0 : trackerToDecoder),
                left: messagesLeft, me: errMultiEnd, to: errTimeout};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event actual=%0h required=none", act);
        end else begin
          req = exp_q.pop_front();
          check("event", 32'(act), 32'(req));
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic start_pkt(input logic [15:0] cnt);
    packetStart  = 1'b1;
    dataValid    = 1'b1;
    messageCount = cnt;
    tick();
    packetStart  = 1'b0;
    dataValid    = 1'b0;
    messageCount = 16'd0;
  endtask

  task automatic type_ok;
    typeValid = 1'b1;
    typeKnown = 1'b1;
    tick();
    typeValid = 1'b0;
    typeKnown = 1'b0;
  endtask

  task automatic pend(input logic [NP-1:0] ends, input logic [NP*TW-1:0] trks);
    parserEnd     = ends;
    parserTracker = trks;
    tick();
    parserEnd     = '0;
    parserTracker = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_startDecode"},  32'(startDecode),      32'd0);
    check({tag, "_tracker"},      32'(trackerToDecoder), 32'd0);
    check({tag, "_busy"},         32'(busy),             32'd0);
    check({tag, "_packetDone"},   32'(packetDone),       32'd0);
    check({tag, "_messagesLeft"}, 32'(messagesLeft),     32'd0);
    check({tag, "_errTimeout"},   32'(errTimeout),       32'd0);
    check({tag, "_errMultiEnd"},  32'(errMultiEnd),      32'd0);
    check({tag, "_state"},        32'(dut.state_q),      32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst = 1'b1; dataValid = 1'b0; packetStart = 1'b0; messageCount = '0;
    typeValid = 1'b0; typeKnown = 1'b0; messageLength = '0;
    parserEnd = '0; parserTracker = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Empty packet: done one cycle later, no decoder start.
    exp_q.push_back(ev_done(1'b0, 1'b0));
    start_pkt(16'd0);
    check("empty_done_pulse", 32'(packetDone), 32'd1);
    tick();
    check("empty_busy_after", 32'(busy), 32'd0);
    wait_drain(10);

    // Three messages all handled by parser 2 with trackers 8, 40, 16.
    exp_q.push_back(ev_start(6'd0, 16'd3, 1'b0, 1'b0));
    start_pkt(16'd3);
    type_ok();
    exp_q.push_back(ev_start(6'd8, 16'd2, 1'b0, 1'b0));
    pend(8'b0000_0100, trk_at(2, 6'd8));
    // Stray packetStart mid-packet must be ignored.
    packetStart = 1'b1; dataValid = 1'b1; messageCount = 16'd9;
    type_ok();
    packetStart = 1'b0; dataValid = 1'b0; messageCount = 16'd0;
    exp_q.push_back(ev_start(6'd40, 16'd1, 1'b0, 1'b0));
    pend(8'b0000_0100, trk_at(2, 6'd40));
    type_ok();
    exp_q.push_back(ev_done(1'b0, 1'b0));
    pend(8'b0000_0100, trk_at(2, 6'd16));
    wait_drain(10);
    check("pkt3_left_zero", 32'(messagesLeft), 32'd0);

    // Unknown type at tracker 40, length 20: tot=25, 3 beats, next tracker 8.
    exp_q.push_back(ev_start(6'd0, 16'd3, 1'b0, 1'b0));
    start_pkt(16'd3);
    type_ok();
    exp_q.push_back(ev_start(6'd40, 16'd2, 1'b0, 1'b0));
    pend(8'b0000_0010, trk_at(1, 6'd40));
    typeValid = 1'b1; typeKnown = 1'b0; messageLength = 16'd20;
    tick();
    typeValid = 1'b0; messageLength = 16'd0;
    check("skip_state", 32'(dut.state_q), 32'(SKIP));
    dataValid = 1'b1; tick();
    dataValid = 1'b0; tick(); tick();
    dataValid = 1'b1; tick(); tick();
    dataValid = 1'b0;
    exp_q.push_back(ev_start(6'd8, 16'd1, 1'b0, 1'b0));
    tick();
    check("skip_resume_start", 32'(startDecode), 32'd1);
    type_ok();
    exp_q.push_back(ev_done(1'b0, 1'b0));
    pend(8'b0000_0001, trk_at(0, 6'd32));
    wait_drain(10);

    // Simultaneous ends from parsers 2 and 5: parser 2 wins, flag sticks.
    exp_q.push_back(ev_start(6'd0, 16'd2, 1'b0, 1'b0));
    start_pkt(16'd2);
    type_ok();
    exp_q.push_back(ev_start(6'd24, 16'd1, 1'b1, 1'b0));
    pend(8'b0010_0100, trk_at(2, 6'd24) | trk_at(5, 6'd48));
    check("multi_flag", 32'(errMultiEnd), 32'd1);
    type_ok();
    exp_q.push_back(ev_done(1'b1, 1'b0));
    pend(8'b1000_0000, trk_at(7, 6'd56));
    wait_drain(10);
    check("multi_sticky", 32'(errMultiEnd), 32'd1);

    // Watchdog in PARSE; new packet clears both flags.
    exp_q.push_back(ev_start(6'd0, 16'd4, 1'b0, 1'b0));
    start_pkt(16'd4);
    type_ok();
    n = 0;
    while (!errTimeout && n < 3 * TO) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO));
    check("timeout_state", 32'(dut.state_q), 32'(ERROR));
    check("timeout_busy", 32'(busy), 32'd1);
    // Events in ERROR must not restart decoding.
    pend(8'b0000_0001, trk_at(0, 6'd8));
    type_ok();
    tick();
    check("error_holds", 32'(dut.state_q), 32'(ERROR));
    exp_q.push_back(ev_start(6'd0, 16'd1, 1'b0, 1'b0));
    start_pkt(16'd1);
    check("restart_clears_timeout", 32'(errTimeout), 32'd0);
    type_ok();
    exp_q.push_back(ev_done(1'b0, 1'b0));
    pend(8'b0000_1000, trk_at(3, 6'd16));
    wait_drain(10);

    // Reset mid-PARSE aborts everything.
    exp_q.push_back(ev_start(6'd0, 16'd5, 1'b0, 1'b0));
    start_pkt(16'd5);
    type_ok();
    check("pre_reset_left", 32'(messagesLeft), 32'd5);
    wait_drain(5);
    rst = 1'b1;
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    tick(); tick();
    check("post_reset_no_events", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
